// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encodings, FSM state type and opcode
// classification helpers for the pipelined ALU.
package alu_pipe_pkg;

  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] OP_XOR = 4'b0000;
  localparam logic [SEL_W-1:0] OP_ADD = 4'b0001;
  localparam logic [SEL_W-1:0] OP_SUB = 4'b0010;
  localparam logic [SEL_W-1:0] OP_AND = 4'b0011;
  localparam logic [SEL_W-1:0] OP_OR  = 4'b0100;
  localparam logic [SEL_W-1:0] OP_EQ  = 4'b0101;
  localparam logic [SEL_W-1:0] OP_LT  = 4'b0110;
  localparam logic [SEL_W-1:0] OP_GT  = 4'b0111;
  localparam logic [SEL_W-1:0] OP_MUL = 4'b1000;
  localparam logic [SEL_W-1:0] OP_SHL = 4'b1001;
  localparam logic [SEL_W-1:0] OP_SHR = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_cmp_op(input logic [SEL_W-1:0] op);
    return (op == OP_EQ) || (op == OP_LT) || (op == OP_GT);
  endfunction

  // Everything above the last defined opcode is reserved.
  function automatic logic is_illegal_op(input logic [SEL_W-1:0] op);
    return op > OP_SHR;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per clock.
//   clk, rst      : clock, async active-high reset (abandons any product)
//   start         : load a/b and begin WIDTH iterations
//   a, b          : operands, sampled on start
//   busy          : iterations in progress
//   done          : current cycle is the last iteration
//   product       : value the accumulator takes at the coming edge; holds
//                   the full a*b product in the cycle done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Down-counter: terminal count 1 marks the final iteration.
  assign done    = busy && (cnt == CNT_W'(1));
  assign product = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe_n.sv
// alu_pipe_n: registered WIDTH-bit ALU with valid/ready handshakes and a
// multi-cycle multiply. Single-cycle ops land in the output registers on the
// accepting edge; MUL lands WIDTH edges later.
//   clk, rst               : clock, async active-high reset
//   in_valid/in_ready      : operand handshake (a, b, sel, cmp_signed)
//   out_valid/out_ready    : result handshake
//   result, result_hi      : low result / MUL upper half (0 otherwise)
//   carry_out .. illegal_op: status flags
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | ready for a new op when the output slot is free
// ST_BUSY | multiplier iterating, input stalled
module alu_pipe_n
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  input  logic             cmp_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             equal,
  output logic             less_than,
  output logic             greater_than,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   d_result;
  logic               d_carry;
  logic               d_zero;
  logic               d_eq;
  logic               d_lt;
  logic               d_gt;
  logic               d_ov;
  logic               d_ill;
  logic [SHW-1:0]     shamt;

  assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);
  assign shamt     = b[SHW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    d_result = '0;
    d_carry  = 1'b0;
    d_eq     = 1'b0;
    d_lt     = 1'b0;
    d_gt     = 1'b0;
    d_ov     = 1'b0;
    d_ill    = 1'b0;
    case (sel)
      OP_XOR: d_result = a ^ b;
      OP_AND: d_result = a & b;
      OP_OR:  d_result = a | b;
      OP_ADD: begin
        {d_carry, d_result} = {1'b0, a} + {1'b0, b};
        d_ov = cmp_signed && (a[WIDTH-1] == b[WIDTH-1]) &&
               (d_result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        d_result = a - b;
        d_carry  = a < b;
        d_ov = cmp_signed && (a[WIDTH-1] != b[WIDTH-1]) &&
               (d_result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_EQ: d_eq = (a == b);
      OP_LT: d_lt = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);
      OP_GT: d_gt = cmp_signed ? ($signed(a) > $signed(b)) : (a > b);
      // Widening by one bit catches the last bit shifted out; shamt==0
      // naturally leaves that bit 0.
      OP_SHL: {d_carry, d_result} = {1'b0, a} << shamt;
      OP_SHR: {d_result, d_carry} = {a, 1'b0} >> shamt;
      OP_MUL: d_result = '0;
      default: d_ill = 1'b1;
    endcase
    d_zero = !is_cmp_op(sel) && !is_illegal_op(sel) &&
             (d_result == '0) && !d_carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      result       <= '0;
      result_hi    <= '0;
      carry_out    <= 1'b0;
      zero         <= 1'b0;
      equal        <= 1'b0;
      less_than    <= 1'b0;
      greater_than <= 1'b0;
      overflow     <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        // Old result was consumed (accept implies it); registers keep
        // their contents until the product arrives.
        state     <= ST_BUSY;
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        result       <= d_result;
        result_hi    <= '0;
        carry_out    <= d_carry;
        zero         <= d_zero;
        equal        <= d_eq;
        less_than    <= d_lt;
        greater_than <= d_gt;
        overflow     <= d_ov;
        illegal_op   <= d_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else begin
      if (mul_done) begin
        state        <= ST_IDLE;
        out_valid    <= 1'b1;
        result       <= mul_product[WIDTH-1:0];
        result_hi    <= mul_product[2*WIDTH-1:WIDTH];
        carry_out    <= |mul_product[2*WIDTH-1:WIDTH];
        zero         <= (mul_product == '0);
        equal        <= 1'b0;
        less_than    <= 1'b0;
        greater_than <= 1'b0;
        overflow     <= 1'b0;
        illegal_op   <= 1'b0;
      end else if (!mul_busy) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule
